// File: rtl/mem_access_ctrl.sv
// Load/store unit that places byte, halfword and word requests onto a synchronous
// single-port RAM. Sub-word stores are done as read-modify-write.
module mem_access_ctrl #(
  parameter int ADDR = 16,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [ADDR+1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR+1:0]   addr_q, addr_d;
  logic [WORD-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [WORD-1:0]   data_q, data_d;

  logic              req_err;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [WORD-1:0]   load_val;
  logic [WORD-1:0]   merged_val;

  assign req_err = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

  // Lane extraction and merge work on the raw RAM word while in CAP.
  always_comb begin
    byte_sel   = mem_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel   = addr_q[1] ? mem_q[31:16] : mem_q[15:0];
    merged_val = mem_q;
    if (size_q == SZ_BYTE) merged_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                   merged_val[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
    case (size_q)
      SZ_BYTE: load_val = {{24{sgn_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{sgn_q & half_sel[15]}}, half_sel};
      default: load_val = mem_q;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        sgn_d   = req_signed;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        err_d   = req_err;
        data_d  = '0;
        if (req_err)                            state_d = RESP;
        else if (req_we && req_size == SZ_WORD) state_d = WR;
        else                                    state_d = RD;
      end
      RD:   state_d = CAP;
      CAP: begin
        data_d  = we_q ? merged_val : load_val;
        state_d = we_q ? WR : RESP;
      end
      WR:   state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Word stores skip the read, so WR takes data straight from the capture.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !we_q && !err_q) ? data_q : '0;
    mem_a      = (state_q == IDLE) ? '0 : addr_q[ADDR+1:2];
    mem_w      = (state_q == WR);
    mem_d      = '0;
    if (state_q == WR) mem_d = (size_q == SZ_WORD) ? wdata_q : data_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table of single requests against a
// behavioural RAM, plus sequences for back-to-back requests and reset handling.
module tb_mem_access_ctrl;

  localparam int ADDR = 8;
  localparam int WORD = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [ADDR+1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic            resp_valid;
  logic [WORD-1:0] resp_rdata;
  logic            resp_err;
  logic [ADDR-1:0] mem_a;
  logic            mem_w;
  logic [WORD-1:0] mem_d;
  logic [WORD-1:0] mem_q;

  logic [WORD-1:0] ram [0:(1<<ADDR)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w) ram[mem_a] <= mem_d;
    else       mem_q      <= ram[mem_a];
  end

  mem_access_ctrl #(.ADDR(ADDR), .WORD(WORD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_w      (mem_w),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  typedef struct {
    string           name;
    logic            we;
    logic [1:0]      size;
    logic            sgn;
    logic [ADDR+1:0] addr;
    logic [WORD-1:0] wdata;
    logic [WORD-1:0] exp_rdata;
    logic            exp_err;
    int              exp_lat;
    int              exp_wr_at;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [ADDR+1:0] addr, input logic [WORD-1:0] wdata,
                     input logic [WORD-1:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_wr_at);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_wr_at = exp_wr_at;
    vecs.push_back(v);
  endtask

  // Issue one request and follow it to its response, scrambling the request
  // inputs after acceptance to show they were captured.
  task automatic run_vec(input vec_t v);
    int lat, wr_at, wr_cnt;
    bit quiet;
    logic [WORD-1:0] rdata;
    logic err;
    lat = 0; wr_at = 0; wr_cnt = 0; quiet = 1'b1; rdata = '0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    check({v.name, "_ready"}, {31'b0, req_ready}, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_w) begin wr_cnt++; wr_at = k; end
      if (resp_valid) begin
        rdata = resp_rdata; err = resp_err; lat = k;
        break;
      end
      if (resp_rdata != '0 || resp_err) quiet = 1'b0;
      if (k == 1) begin
        req_valid = 1'b0; req_addr = ~req_addr; req_wdata = ~req_wdata;
        req_signed = ~req_signed; req_we = ~req_we;
      end
    end
    req_valid = 1'b0;
    check({v.name, "_lat"},   lat,   v.exp_lat);
    check({v.name, "_rdata"}, rdata, v.exp_rdata);
    check({v.name, "_err"},   {31'b0, err}, {31'b0, v.exp_err});
    check({v.name, "_wr_at"}, wr_at, v.exp_wr_at);
    check({v.name, "_wr_cnt"}, wr_cnt, (v.exp_wr_at != 0) ? 1 : 0);
    check({v.name, "_quiet"}, {31'b0, quiet}, 32'd1);
    @(negedge clk);
    check({v.name, "_back_idle"}, {30'b0, req_ready, resp_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    int wr_cnt;

    // word stores preload; wr_at is the cycle after acceptance where mem_w=1
    add("st_w5",      1, 2'b10, 0, 10'h014, 32'h8899AABB, 32'h0,        0, 2, 1);
    add("st_w2",      1, 2'b10, 0, 10'h008, 32'h11223344, 32'h0,        0, 2, 1);
    add("ld_w5",      0, 2'b10, 0, 10'h014, 32'h0,        32'h8899AABB, 0, 3, 0);
    add("ld_b16_s",   0, 2'b00, 1, 10'h016, 32'h0,        32'hFFFFFF99, 0, 3, 0);
    add("ld_b16_u",   0, 2'b00, 0, 10'h016, 32'h0,        32'h00000099, 0, 3, 0);
    add("ld_b14_s",   0, 2'b00, 1, 10'h014, 32'h0,        32'hFFFFFFBB, 0, 3, 0);
    add("ld_b15_u",   0, 2'b00, 0, 10'h015, 32'h0,        32'h000000AA, 0, 3, 0);
    add("ld_h16_s",   0, 2'b01, 1, 10'h016, 32'h0,        32'hFFFF8899, 0, 3, 0);
    add("ld_h14_u",   0, 2'b01, 0, 10'h014, 32'h0,        32'h0000AABB, 0, 3, 0);
    add("st_h0a",     1, 2'b01, 0, 10'h00A, 32'hDEADBEEF, 32'h0,        0, 4, 3);
    add("ld_w2_a",    0, 2'b10, 0, 10'h008, 32'h0,        32'hBEEF3344, 0, 3, 0);
    add("st_b09",     1, 2'b00, 1, 10'h009, 32'hFFFFFF55, 32'h0,        0, 4, 3);
    add("ld_w2_b",    0, 2'b10, 0, 10'h008, 32'h0,        32'hBEEF5544, 0, 3, 0);
    add("err_ld_w13", 0, 2'b10, 0, 10'h013, 32'h0,        32'h0,        1, 1, 0);
    add("err_ld_h15", 0, 2'b01, 1, 10'h015, 32'h0,        32'h0,        1, 1, 0);
    add("err_st_sz3", 1, 2'b11, 0, 10'h010, 32'h12345678, 32'h0,        1, 1, 0);
    add("err_st_w12", 1, 2'b10, 0, 10'h012, 32'h12345678, 32'h0,        1, 1, 0);
    add("ld_w5_again",0, 2'b10, 0, 10'h014, 32'h0,        32'h8899AABB, 0, 3, 0);

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp",  {30'b0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_mem",   {31'b0, mem_w} | {24'b0, mem_a} | mem_d, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset wins over a simultaneous request
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 10'h030; req_wdata = 32'h0BADF00D;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rstprec_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("rstprec_quiet", {30'b0, resp_valid, mem_w}, 32'd0);

    // back-to-back: store with req_valid held high, load accepted right after RESP
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 10'h020; req_wdata = 32'hCAFEF00D;
    lat = 0; wr_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_w) wr_cnt++;
      if (resp_valid) begin lat = k; break; end
    end
    check("b2b_st_lat", lat, 2);
    req_we = 1'b0;
    @(negedge clk);
    check("b2b_ready_after_resp", {31'b0, req_ready}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_w) wr_cnt++;
      if (resp_valid) begin
        lat = k;
        check("b2b_ld_rdata", resp_rdata, 32'hCAFEF00D);
        break;
      end
    end
    check("b2b_ld_lat", lat, 3);
    check("b2b_wr_cnt", wr_cnt, 1);

    // reset while in CAP of a byte store
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 10'h020; req_wdata = 32'h77;
    wr_cnt = 0; lat = 0;
    @(negedge clk);
    req_valid = 1'b0;
    if (mem_w) wr_cnt++;
    if (resp_valid) lat++;
    @(negedge clk);
    if (mem_w) wr_cnt++;
    if (resp_valid) lat++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_outs", {31'b0, mem_w} | {24'b0, mem_a} | mem_d | resp_rdata, 32'h0);
    repeat (4) begin
      @(negedge clk);
      if (mem_w) wr_cnt++;
      if (resp_valid) lat++;
    end
    check("midrst_no_write", wr_cnt, 0);
    check("midrst_no_resp", lat, 0);
    check("midrst_ram", ram[8], 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 16: word-address width of the data memory port.
REQ-002 SHALL have parameter WORD, default 32: data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when req_valid && req_ready.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port req_signed  input  1  sign-extend sub-word loads; ignored for stores.
REQ-010 SHALL have port req_addr  input  ADDR+2  byte address.
REQ-011 SHALL have port req_wdata  input  WORD  store data, right-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  WORD  load result; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned or illegal-size request; valid with resp_valid.
REQ-015 SHALL have ports mem_a (output, ADDR), mem_w (output, 1), mem_d (output, WORD) and mem_q (input, WORD) to a synchronous single-port RAM:
  - the RAM writes mem_d on an edge where mem_w=1;
  - otherwise it registers the read, so mem_q is valid one cycle after mem_a is presented with mem_w=0;
  - mem_q holds its value during writes.

Function
REQ-016 SHALL capture req_we, req_size, req_signed, req_addr and req_wdata on acceptance; later input changes are ignored.
REQ-017 SHALL drive mem_a = captured req_addr[ADDR+1:2].
REQ-018 SHALL use little-endian lanes: byte k = bits 8k+7:8k, selected by addr[1:0]; halfword selected by addr[1].
REQ-019 SHALL implement FSM states IDLE, RD, CAP, WR, RESP.
REQ-020 SHALL assert req_ready=1 only in IDLE.
REQ-021 SHALL, in IDLE, drive mem_w=0, mem_a=0 and mem_d=0.
REQ-022 SHALL treat as error: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-023 SHALL, on an accepted error request, go IDLE->RESP with no memory access.
REQ-024 SHALL sequence an accepted word store as IDLE->WR->RESP.
REQ-025 SHALL sequence an accepted load as IDLE->RD->CAP->RESP.
REQ-026 SHALL sequence an accepted byte or halfword store as IDLE->RD->CAP->WR->RESP (read-modify-write).
REQ-027 SHALL drive mem_w=0 in RD.
REQ-028 SHALL register mem_q in CAP into an internal data register.
REQ-029 SHALL, in CAP for a load, extract the addressed lane and zero- or sign-extend it per req_signed.
REQ-030 SHALL, in CAP for a sub-word store, replace only the addressed lane(s) with req_wdata[7:0] or [15:0]; all other bits keep their mem_q value.
REQ-031 SHALL, in WR, drive mem_w=1 for exactly one cycle; mem_d = req_wdata (word store) or the merged word (sub-word store).
REQ-032 SHALL assert mem_w=1 in no state other than WR.
REQ-033 SHALL, in RESP, assert resp_valid=1 for exactly one cycle and return to IDLE next cycle; resp_err=1 only for error requests.
REQ-034 SHALL produce resp_valid relative to an acceptance edge at cycle T:
  - error: T+1
  - word store: T+2
  - load: T+3
  - sub-word store: T+4
REQ-035 SHALL allow a new request to be accepted in the cycle after RESP; at most one request is in flight.
REQ-036 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid=0.
REQ-037 SHALL accept no request while busy; req_valid in non-IDLE states is ignored and has no side effect.

Reset
REQ-038 SHALL, with rst=1 at a posedge, force state IDLE and zero all internal registers; after that edge req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_w=0, mem_a=0, mem_d=0.
REQ-039 SHALL, on rst during any non-IDLE state, abandon the operation with no resp_valid; a pending WR is suppressed if rst is high at that edge.
REQ-040 SHALL take rst precedence over a simultaneous req_valid.

Verification
REQ-041 SHALL cover a word load: RAM[5]=0x8899AABB; load word, addr 0x14 -> resp_valid at T+3, rdata=0x8899AABB, err=0.
REQ-042 SHALL cover signed and unsigned byte loads: RAM[5]=0x8899AABB; signed byte load, addr 0x16 -> rdata=0xFFFFFF99; the same access unsigned -> 0x00000099.
REQ-043 SHALL cover a halfword store: RAM[2]=0x11223344; halfword store, addr 0x0A, wdata=0xDEADBEEF -> exactly one mem_w pulse at T+3, RAM[2]=0xBEEF3344, resp_valid at T+4.
REQ-044 SHALL cover a misaligned word load: addr 0x13 -> resp_valid at T+1, err=1, rdata=0, mem_w never asserted.
REQ-045 SHALL cover back-to-back requests: word store to addr 0x20 with 0xCAFEF00D held on req_valid, then a load of the same address accepted in the cycle after RESP -> rdata=0xCAFEF00D.
REQ-046 SHALL cover reset mid-operation: rst asserted while in CAP of a byte store -> no mem_w, no resp_valid; RAM unchanged; req_ready=1 the cycle after the reset edge.
